// File: rtl/bg_mem_arbiter.sv
// Background frame memory port arbiter: display reads own the port in active video,
// a req/ack writer is served in blanking. Define BG_MEM_WR_DURING_HBLNK_EN to also allow writes in hblank.
module bg_mem_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 4,
  parameter int FRAME_W = 400,
  parameter int FRAME_H = 300,
  parameter int CNT_W   = 20
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic [1:0] {DISP = 2'd0, FREE = 2'd1, WR = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(FRAME_W * FRAME_H);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                wr_ack_q, wr_ack_d;
  logic                wr_err_q, wr_err_d;
  logic [2:0]          vld_pipe_q;
  logic [DATA_W-1:0]   pix_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vblnk_q;
  logic                free, wr_acc, vblnk_rise;
  logic [ADDR_W-1:0]   disp_addr;

`ifdef BG_MEM_WR_DURING_HBLNK_EN
  assign free = hblnk_in | vblnk_in;
  logic unused_bits;
  assign unused_bits = ^{hcount_in[0], vcount_in[0]};
`else
  assign free = vblnk_in;
  logic unused_bits;
  assign unused_bits = ^{hcount_in[0], vcount_in[0], hblnk_in};
`endif

  // One memory word per 2x2 screen block.
  assign disp_addr = ADDR_W'(hcount_in[10:1])
                   + ADDR_W'(vcount_in[10:1]) * ADDR_W'(FRAME_W);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    wr_err_d    = 1'b0;
    wr_acc      = 1'b0;
    case (state_q)
      DISP: begin
        mem_addr_d = disp_addr;
        if (free) state_d = FREE;
      end
      FREE: begin
        if (!free) state_d = DISP;
        else if (wr_req) begin
          // The write's outputs are registered here and appear during WR.
          state_d  = WR;
          wr_ack_d = 1'b1;
          if (wr_addr >= FRAME_PIX) wr_err_d = 1'b1;
          else begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            mem_we_d    = 1'b1;
            wr_acc      = 1'b1;
          end
        end
      end
      WR:      state_d = free ? FREE : DISP;
      default: state_d = DISP;
    endcase
  end

  assign vblnk_rise = vblnk_in & ~vblnk_q;

  always_comb begin
    cnt_d = cnt_q;
    if (vblnk_rise)                 cnt_d = wr_acc ? CNT_W'(1) : '0;
    else if (wr_acc && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= DISP;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      vld_pipe_q  <= '0;
      pix_q       <= '0;
      cnt_q       <= '0;
      vblnk_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      vld_pipe_q  <= {vld_pipe_q[1:0], state_q == DISP};
      pix_q       <= vld_pipe_q[1] ? mem_rdata : '0;
      cnt_q       <= cnt_d;
      vblnk_q     <= vblnk_in;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign wr_ack    = wr_ack_q;
  assign wr_err    = wr_err_q;
  assign pix_out   = pix_q;
  assign pix_valid = vld_pipe_q[2];
  assign wr_count  = cnt_q;

endmodule

// File: tb/tb_bg_mem_arbiter.sv
// Directed/randomized bench for bg_mem_arbiter against arithmetic expectations.
module tb_bg_mem_arbiter;
  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount, vcount;
  logic        hblnk, vblnk, wr_req;
  logic [21:0] wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ack, wr_err, mem_we, pix_valid;
  logic [21:0] mem_addr;
  logic [3:0]  mem_wdata, pix_out;
  logic [3:0]  mem_rdata = '0;
  logic [19:0] wr_count;

  int errors = 0;
  int checks = 0;
  int cnt_exp = 0;

  bg_mem_arbiter dut (
    .pclk(pclk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
    .hblnk_in(hblnk), .vblnk_in(vblnk), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .pix_out(pix_out), .pix_valid(pix_valid), .wr_count(wr_count)
  );

  always #5 pclk = ~pclk;

  function automatic logic [3:0] pat(input logic [21:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction

  // Synchronous-read frame memory whose contents are a known function of address.
  always @(posedge pclk) mem_rdata <= pat(mem_addr);

  function automatic int unsigned daddr(input int unsigned h, input int unsigned v);
    return (h / 2) + (v / 2) * 400;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic wait_ack(input int maxc, output int n);
    n = 0;
    do begin tick(); n++; end while (!wr_ack && n < maxc);
    chk("ack_seen", wr_ack, 1);
  endtask

  task automatic do_write(input logic [21:0] a, input logic [3:0] d, input bit ok,
                          input string tag, output int n);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    wait_ack(8, n);
    if (ok) cnt_exp++;
    chk({tag, "_err"}, wr_err, !ok);
    chk({tag, "_we"}, mem_we, ok);
    if (ok) begin
      chk({tag, "_addr"}, mem_addr, a);
      chk({tag, "_data"}, mem_wdata, d);
    end
    chk({tag, "_cnt"}, wr_count, cnt_exp);
    wr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ea[0:31];
    int unsigned h, v;
    int n;
    logic [21:0] a;
    logic [3:0]  d;

    // Reset state
    rst = 1'b1; hcount = '0; vcount = '0; hblnk = 1'b0; vblnk = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_ack", wr_ack, 0);
    chk("rst_err", wr_err, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_pv", pix_valid, 0);
    chk("rst_cnt", wr_count, 0);
    rst = 1'b0;

    // Active video: address generation and 3-cycle pixel return
    for (int k = 0; k < 24; k++) begin
      if (k == 0) begin h = 10; v = 6; end
      else begin h = $urandom_range(799, 0); v = $urandom_range(599, 0); end
      hcount = 11'(h); vcount = 11'(v); ea[k] = daddr(h, v);
      tick();
      if (k == 0) chk("addr_1205", mem_addr, 1205);
      chk("disp_addr", mem_addr, ea[k]);
      chk("disp_we", mem_we, 0);
      if (k >= 2) begin
        chk("pix_valid", pix_valid, 1);
        chk("pix_out", pix_out, pat(ea[k-2]));
      end
    end

    // Vertical blank: back-to-back writes, addr 0..3 then random legal ones
    vblnk = 1'b1; cnt_exp = 0;
    for (int i = 0; i < 8; i++) begin
      a = (i < 4) ? 22'(i) : 22'($urandom_range(119998, 0));
      d = 4'($urandom);
      do_write(a, d, 1'b1, "vb_wr", n);
      chk("vb_gap", n, 2);
      if (i == 3) chk("vb_cnt4", wr_count, 4);
    end
    chk("blank_pv", pix_valid, 0);
    chk("blank_pix", pix_out, 0);

    // Range check boundaries
    do_write(22'd120000, 4'hF, 1'b0, "oor_lo", n);
    do_write(22'($urandom_range(4194303, 120001)), 4'h5, 1'b0, "oor_rnd", n);
    do_write(22'd119999, 4'h9, 1'b1, "last_px", n);

    // Reset during the WR cycle of a pending write
    a = 22'd777; d = 4'h6;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    n = 0;
    do begin tick(); n++; end while (!mem_we && n < 8);
    chk("mid_we_seen", mem_we, 1);
    rst = 1'b1; #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_ack", wr_ack, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_cnt", wr_count, 0);
    tick(); rst = 1'b0; cnt_exp = 0;
    do_write(a, d, 1'b1, "reissue", n);
    chk("reissue_lat", n, 2);

    // Request rises as the window closes: display wins until next window
    tick();
    vblnk = 1'b0; wr_req = 1'b1; wr_addr = 22'd4242; wr_data = 4'hC;
    for (int j = 0; j < 20; j++) begin
      h = $urandom_range(799, 0); v = $urandom_range(599, 0);
      hcount = 11'(h); vcount = 11'(v);
      tick();
      chk("race_noack", wr_ack, 0);
      chk("race_we", mem_we, 0);
      if (j >= 1) chk("race_addr", mem_addr, daddr(h, v));
    end
    vblnk = 1'b1; cnt_exp = 0;
    do_write(22'd4242, 4'hC, 1'b1, "race_wr", n);
    chk("race_lat", n, 2);

    // Horizontal blank only
    vblnk = 1'b0; hblnk = 1'b0;
    repeat (3) tick();
    hblnk = 1'b1;
`ifdef BG_MEM_WR_DURING_HBLNK_EN
    do_write(22'd1000, 4'h3, 1'b1, "hb_wr", n);
    chk("hb_lat", n, 2);
`else
    wr_req = 1'b1; wr_addr = 22'd1000; wr_data = 4'h3;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("hb_noack", wr_ack, 0);
      chk("hb_we", mem_we, 0);
    end
    vblnk = 1'b1; cnt_exp = 0;
    do_write(22'd1000, 4'h3, 1'b1, "hb_vb_wr", n);
    chk("hb_vb_lat", n, 2);
`endif

    // Counter clears on the next vblank rising edge
    hblnk = 1'b0; vblnk = 1'b0;
    repeat (2) tick();
    vblnk = 1'b1; cnt_exp = 0;
    tick();
    chk("cnt_clear", wr_count, cnt_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
